dot_stream_mac: RTL



---
 rtl/dot_stream_mac_pkg.sv | 19 +
 rtl/dot_stream_mac_if.sv | 29 ++
 rtl/dot_stream_mac_lane.sv | 60 ++++++
 rtl/dot_stream_mac.sv | 107 ++++++++++
 4 files changed

// File: rtl/dot_stream_mac_pkg.sv
// dot_pkg: shared constants and types for the streaming dot-product MAC.
//   N_DEF / W_DEF / ACC_W_DEF : default vector length, element width and
//                               accumulator width.
//   SEXT_W                    : bits of sign extension from the 2*W product
//                               up to the accumulator width.
//   state_e                   : controller states (DRAIN only reachable when
//                               DOT_STREAM_MAC_PIPE_EN is defined).
package dot_pkg;
   localparam int N_DEF     = 64;
   localparam int W_DEF     = 16;
   localparam int ACC_W_DEF = 48;
   localparam int SEXT_W    = ACC_W_DEF - 2 * W_DEF;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_e;
endpackage

// File: rtl/dot_stream_mac_if.sv
// dot_stream_mac_if: element-pair input stream plus scalar result stream.
//   in_valid/in_ready/in_a/in_b     : one signed element pair per handshake
//   out_valid/out_ready/out_data    : signed dot product result
//   elem_cnt                        : pairs accepted in the current vector
// Modports: master = stream source / result sink, slave = the MAC block.
interface dot_stream_mac_if #(
   parameter int N     = dot_pkg::N_DEF,
   parameter int W     = dot_pkg::W_DEF,
   parameter int ACC_W = dot_pkg::ACC_W_DEF
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [W-1:0]     in_a;
   logic signed [W-1:0]     in_b;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic [$clog2(N)-1:0]    elem_cnt;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, elem_cnt
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, elem_cnt
   );
endinterface

// File: rtl/dot_stream_mac_lane.sv
// dot_mac_lane: signed W x W multiply, sign-extended to ACC_W.
//   clk, rst : clock and synchronous active-high reset
//   en_i     : a pair is being accepted this cycle
//   a_i, b_i : signed operands
//   prod_o   : sign-extended product presented to the accumulator
//   vld_o    : prod_o must be added this cycle
// With DOT_STREAM_MAC_PIPE_EN defined the product is registered, so prod_o /
// vld_o lag en_i by one cycle; otherwise the lane is purely combinational.
module dot_mac_lane #(
   parameter int W     = dot_pkg::W_DEF,
   parameter int ACC_W = dot_pkg::ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic signed [W-1:0]     a_i,
   input  logic signed [W-1:0]     b_i,
   output logic signed [ACC_W-1:0] prod_o,
   output logic                    vld_o
);
   localparam int EXT_W = ACC_W - 2 * W;

   logic signed [2*W-1:0]   prod;
   logic signed [ACC_W-1:0] prod_ext;

   // Widen both operands first so the multiply is a full signed 2*W product.
   assign prod = (2 * W)'(a_i) * (2 * W)'(b_i);

   if (EXT_W > 0) begin : g_ext
      assign prod_ext = {{EXT_W{prod[2*W-1]}}, prod};
   end else begin : g_noext
      assign prod_ext = prod;
   end

`ifdef DOT_STREAM_MAC_PIPE_EN
   logic signed [ACC_W-1:0] prod_q;
   logic                    vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= en_i;
         if (en_i) begin
            prod_q <= prod_ext;
         end
      end
   end

   assign prod_o = prod_q;
   assign vld_o  = vld_q;
`else
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, clk, rst};

   assign prod_o = prod_ext;
   assign vld_o  = en_i;
`endif
endmodule

// File: rtl/dot_stream_mac.sv
// dot_stream_mac: streaming signed dot product of two N-element vectors.
//   clk, rst : sole clock, synchronous active-high reset
//   bus      : dot_stream_mac_if.slave (pair input stream, result output,
//              elem_cnt)
// Optional macro DOT_STREAM_MAC_PIPE_EN registers the product between the
// multiplier and the adder and inserts one DRAIN cycle after the last pair.
// The accumulator wraps modulo 2^ACC_W.
module dot_stream_mac
   import dot_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int W     = W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   dot_stream_mac_if.slave bus
);
   localparam int              CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] out_q, out_d;
   logic signed [ACC_W-1:0] lane_prod;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    lane_vld;
   logic                    accept;

   assign accept  = bus.in_valid && (state_q == ACCUM);
   assign acc_sum = acc_q + lane_prod;

   dot_mac_lane #(.W(W), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (accept),
      .a_i   (bus.in_a),
      .b_i   (bus.in_b),
      .prod_o(lane_prod),
      .vld_o (lane_vld)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      out_d   = out_q;

      if (lane_vld) begin
         acc_d = acc_sum;
      end

      case (state_q)
         ACCUM: begin
            if (accept) begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
`ifdef DOT_STREAM_MAC_PIPE_EN
                  // Last product is still in the lane register; retire it in DRAIN.
                  state_d = DRAIN;
`else
                  state_d = HOLD;
                  out_d   = acc_sum;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef DOT_STREAM_MAC_PIPE_EN
         DRAIN: begin
            state_d = HOLD;
            out_d   = acc_sum;
         end
`endif
         HOLD: begin
            if (bus.out_ready) begin
               state_d = ACCUM;
               acc_d   = '0;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = out_q;
   assign bus.elem_cnt  = cnt_q;
endmodule
